// File: rtl/boot_loader.sv
// Length-prefixed, XOR-checksummed program loader: assembles big-endian words from a
// byte stream, writes them to instruction memory and releases the CPU on a verified image.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          COUNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               mem_write_enable,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_write_data,
    output logic [3:0]         mem_select_signal,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [COUNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_e             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        len_q, len_d;
    logic [23:0]        word_q, word_d;
    logic [7:0]         checksum_q, checksum_d;
    logic [COUNT_W-1:0] words_loaded_q, words_loaded_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         sel_q, sel_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic        accept;
    logic [31:0] len_shift;
    logic [31:0] word_shift;

    assign rx_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
    assign accept     = rx_valid && rx_ready;
    assign len_shift  = {len_q[23:0], rx_data};
    assign word_shift = {word_q, rx_data};

    // NOTE: every _d gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        len_d          = len_q;
        word_d         = word_q;
        checksum_d     = checksum_q;
        words_loaded_d = words_loaded_q;
        we_d           = 1'b0;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        sel_d          = 4'b0000;
        cpu_reset_d    = cpu_reset_q;
        done_d         = done_q;
        error_d        = error_q;

        unique case (state_q)
            S_LEN: begin
                if (accept) begin
                    len_d      = len_shift;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (len_shift > MAX_N) begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                        end else if (len_shift == 32'd0) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d     = word_shift[23:0];
                    checksum_d = checksum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: strobe the write and count it in the same cycle.
                        we_d           = 1'b1;
                        addr_d         = BASE_ADDR + (32'(words_loaded_q) << 2);
                        wdata_d        = word_shift;
                        sel_d          = 4'b1111;
                        words_loaded_d = words_loaded_q + COUNT_W'(1);
                        if (32'(words_loaded_q) + 32'd1 == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (rx_data == checksum_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE, S_ERROR: begin
            end
            default: begin
                state_d = S_ERROR;
                error_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_LEN;
            byte_idx_q     <= 2'd0;
            len_q          <= 32'd0;
            word_q         <= 24'd0;
            checksum_q     <= 8'd0;
            words_loaded_q <= '0;
            we_q           <= 1'b0;
            addr_q         <= BASE_ADDR;
            wdata_q        <= 32'd0;
            sel_q          <= 4'b0000;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            len_q          <= len_d;
            word_q         <= word_d;
            checksum_q     <= checksum_d;
            words_loaded_q <= words_loaded_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            sel_q          <= sel_d;
            cpu_reset_q    <= cpu_reset_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign mem_write_enable  = we_q;
    assign mem_addr          = addr_q;
    assign mem_write_data    = wdata_q;
    assign mem_select_signal = sel_q;
    assign cpu_reset         = cpu_reset_q;
    assign load_done         = done_q;
    assign load_error        = error_q;
    assign words_loaded      = words_loaded_q;

endmodule
